// File: rtl/lisnoc_vc_credit_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lisnoc_vc_credit_scheduler_if
// Brief    : FIFO-side, link-side and credit signals of the VC credit scheduler
// Revision : 1.0
// ============================================================================
interface lisnoc_vc_credit_scheduler_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int VCHANNELS  = 2
);
  logic [VCHANNELS-1:0]            fifo_valid_i;
  logic [FLIT_WIDTH*VCHANNELS-1:0] fifo_flit_i;
  logic [VCHANNELS-1:0]            fifo_ready_o;
  logic [FLIT_WIDTH-1:0]           link_flit_o;
  logic [VCHANNELS-1:0]            link_valid_o;
  logic [VCHANNELS-1:0]            credit_return_i;
  logic                            credit_err_o;

  // Environment side: FIFOs and downstream credit source.
  modport master (
    output fifo_valid_i, fifo_flit_i, credit_return_i,
    input  fifo_ready_o, link_flit_o, link_valid_o, credit_err_o
  );

  // Scheduler side.
  modport slave (
    input  fifo_valid_i, fifo_flit_i, credit_return_i,
    output fifo_ready_o, link_flit_o, link_valid_o, credit_err_o
  );
endinterface
`default_nettype wire

// File: rtl/lisnoc_vc_credit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lisnoc_vc_credit_scheduler
// Brief    : credit-based flit-level round-robin VC scheduler for one output link
// Revision : 1.0
// ============================================================================
module lisnoc_vc_credit_scheduler #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VCHANNELS       = 2,
  parameter int CREDITS         = 4,
  parameter int LOCK_PACKETS    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  lisnoc_vc_credit_scheduler_if.slave  bus
);

  localparam int FW = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  localparam logic [1:0]    TYPE_HEADER = 2'b01;
  localparam logic [1:0]    TYPE_LAST   = 2'b10;
  localparam logic [CW-1:0] CNT_FULL    = CW'(CREDITS);
  localparam logic [PW-1:0] PTR_RESET   = PW'(VCHANNELS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state;
  logic [PW-1:0]          lock_vc;
  logic [PW-1:0]          ptr;
  logic [VCHANNELS-1:0]   link_valid;
  logic [FW-1:0]          link_flit;
  logic                   credit_err;

  logic [CW-1:0]          cnt      [VCHANNELS];
  logic [FW-1:0]          masked   [VCHANNELS];
  logic [VCHANNELS-1:0]   eligible;
  logic [VCHANNELS-1:0]   overflow;
  logic [VCHANNELS-1:0]   grant;
  logic [PW-1:0]          grant_idx;
  logic                   any_grant;
  logic [FW-1:0]          grant_flit;
  logic [1:0]             grant_type;

  // Per-VC credit counters; a grant and a return in the same cycle cancel out.
  for (genvar v = 0; v < VCHANNELS; v++) begin : g_credit
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count <= CNT_FULL;
      end else begin
        case ({grant[v], bus.credit_return_i[v]})
          2'b10:   count <= count - CW'(1);
          2'b01:   if (count != CNT_FULL) count <= count + CW'(1);
          default: count <= count;
        endcase
      end
    end

    assign cnt[v]      = count;
    assign eligible[v] = bus.fifo_valid_i[v] && (count != '0);
    assign overflow[v] = bus.credit_return_i[v] && !grant[v] && (count == CNT_FULL);
    assign masked[v]   = {FW{grant[v]}} & bus.fifo_flit_i[v*FW +: FW];
  end

  always_comb begin
    logic [PW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (!rst) begin
      if (state == LOCKED) begin
        // Other VCs wait while the locked VC is stalled.
        if (eligible[lock_vc]) begin
          grant[lock_vc] = 1'b1;
          grant_idx      = lock_vc;
          any_grant      = 1'b1;
        end
      end else begin
        for (int i = 1; i <= VCHANNELS; i++) begin
          idx = PW'((int'(ptr) + i) % VCHANNELS);
          if (!any_grant && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_grant  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant_flit = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      grant_flit = grant_flit | masked[v];
    end
  end

  assign grant_type = grant_flit[FW-1 -: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_vc    <= '0;
      ptr        <= PTR_RESET;
      link_valid <= '0;
      link_flit  <= '0;
      credit_err <= 1'b0;
    end else begin
      link_valid <= grant;
      if (any_grant) begin
        link_flit <= grant_flit;
        ptr       <= grant_idx;
      end
      if (|overflow) begin
        credit_err <= 1'b1;
      end
      if ((LOCK_PACKETS != 0) && any_grant) begin
        case (state)
          IDLE: begin
            if (grant_type == TYPE_HEADER) begin
              state   <= LOCKED;
              lock_vc <= grant_idx;
            end
          end
          LOCKED: begin
            if (grant_type == TYPE_LAST) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_ready_o = grant;
  assign bus.link_valid_o = link_valid;
  assign bus.link_flit_o  = link_flit;
  assign bus.credit_err_o = credit_err;

endmodule
`default_nettype wire

// File: tb/tb_lisnoc_vc_credit_scheduler.sv
`default_nettype none
// Bench for lisnoc_vc_credit_scheduler: one instance without and one with packet locking,
// driven from a vector table plus hand-written lock and reset sequences.
module tb_lisnoc_vc_credit_scheduler;

  localparam int FW = 34;
  localparam logic [1:0] PAY = 2'b00;
  localparam logic [1:0] HDR = 2'b01;
  localparam logic [1:0] LST = 2'b10;
  localparam logic [1:0] SGL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lisnoc_vc_credit_scheduler_if #(.FLIT_WIDTH(FW), .VCHANNELS(2)) bus0 ();
  lisnoc_vc_credit_scheduler_if #(.FLIT_WIDTH(FW), .VCHANNELS(2)) bus1 ();

  lisnoc_vc_credit_scheduler #(
    .FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .VCHANNELS(2), .CREDITS(4), .LOCK_PACKETS(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  lisnoc_vc_credit_scheduler #(
    .FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .VCHANNELS(2), .CREDITS(4), .LOCK_PACKETS(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [1:0]    valid;
    logic [FW-1:0] f0;
    logic [FW-1:0] f1;
    logic [1:0]    ret;
    logic [1:0]    exp_rdy;
    logic          exp_err;
    string         nm;
  } vec_t;

  typedef struct {
    logic [1:0]    vld;
    logic [FW-1:0] flit;
  } sb_t;

  vec_t          tbl[$];
  sb_t           q0[$];
  sb_t           q1[$];
  logic [FW-1:0] hold0, hold1;
  bit            chk0, chk1;
  int            total  = 0;
  int            passed = 0;

  function automatic logic [FW-1:0] mkf(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  function automatic vec_t mkv(input logic [1:0] valid, input logic [FW-1:0] f0,
                               input logic [FW-1:0] f1, input logic [1:0] ret,
                               input logic [1:0] exp_rdy, input logic exp_err, input string nm);
    vec_t v;
    v.valid = valid; v.f0 = f0; v.f1 = f1; v.ret = ret;
    v.exp_rdy = exp_rdy; v.exp_err = exp_err; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] valid, input logic [FW-1:0] f0,
                       input logic [FW-1:0] f1, input logic [1:0] ret);
    bus0.fifo_valid_i = valid; bus0.fifo_flit_i = {f1, f0}; bus0.credit_return_i = ret;
    bus1.fifo_valid_i = valid; bus1.fifo_flit_i = {f1, f0}; bus1.credit_return_i = ret;
  endtask

  // One clock: grant checked before the edge, link output checked after it via the scoreboard.
  task automatic cycle(input vec_t v);
    sb_t e;
    drive(v.valid, v.f0, v.f1, v.ret);
    @(negedge clk);
    if (chk0) begin
      check($sformatf("%s.ready0", v.nm), bus0.fifo_ready_o, v.exp_rdy);
      if (v.exp_rdy[0]) hold0 = v.f0; else if (v.exp_rdy[1]) hold0 = v.f1;
      q0.push_back('{v.exp_rdy, hold0});
    end
    if (chk1) begin
      check($sformatf("%s.ready1", v.nm), bus1.fifo_ready_o, v.exp_rdy);
      if (v.exp_rdy[0]) hold1 = v.f0; else if (v.exp_rdy[1]) hold1 = v.f1;
      q1.push_back('{v.exp_rdy, hold1});
    end
    @(posedge clk);
    #1;
    if (chk0 && q0.size() > 0) begin
      e = q0.pop_front();
      check($sformatf("%s.link_valid0", v.nm), bus0.link_valid_o, e.vld);
      check($sformatf("%s.link_flit0", v.nm), bus0.link_flit_o, e.flit);
      check($sformatf("%s.err0", v.nm), bus0.credit_err_o, v.exp_err);
    end
    if (chk1 && q1.size() > 0) begin
      e = q1.pop_front();
      check($sformatf("%s.link_valid1", v.nm), bus1.link_valid_o, e.vld);
      check($sformatf("%s.link_flit1", v.nm), bus1.link_flit_o, e.flit);
      check($sformatf("%s.err1", v.nm), bus1.credit_err_o, v.exp_err);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check($sformatf("%s.link_valid0", nm), bus0.link_valid_o, '0);
    check($sformatf("%s.link_flit0", nm),  bus0.link_flit_o,  '0);
    check($sformatf("%s.ready0", nm),      bus0.fifo_ready_o, '0);
    check($sformatf("%s.err0", nm),        bus0.credit_err_o, '0);
    check($sformatf("%s.link_valid1", nm), bus1.link_valid_o, '0);
    check($sformatf("%s.link_flit1", nm),  bus1.link_flit_o,  '0);
    check($sformatf("%s.ready1", nm),      bus1.fifo_ready_o, '0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    hold0 = '0; hold1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected $finish");
    $fatal(1);
  end

  initial begin
    // Vector table: round-robin drain, zero-credit skip, credit cancel and saturation.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA000_0000 + i), mkf(PAY, 32'hB000_0000 + i),
                        2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, $sformatf("t1_rr%0d", i)));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA100_0000 + i), mkf(PAY, 32'hB100_0000 + i),
                        2'b00, 2'b00, 1'b0, $sformatf("t1_empty%0d", i)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b0, $sformatf("t2_refill%0d", i)));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0000), mkf(PAY, 32'hB200_0000), 2'b00, 2'b01, 1'b0, "t2_skip_vc1"));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0001), mkf(PAY, 32'hB200_0001), 2'b10, 2'b01, 1'b0, "t2_ret_same_cycle"));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0002), mkf(PAY, 32'hB200_0002), 2'b00, 2'b10, 1'b0, "t2_vc1_once"));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0003), mkf(PAY, 32'hB200_0003), 2'b00, 2'b01, 1'b0, "t2_vc0_a"));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0004), mkf(PAY, 32'hB200_0004), 2'b00, 2'b01, 1'b0, "t2_vc0_b"));
    tbl.push_back(mkv(2'b11, mkf(PAY, 32'hA200_0005), mkf(PAY, 32'hB200_0005), 2'b00, 2'b00, 1'b0, "t2_dry"));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b0, $sformatf("t3_refill%0d", i)));
    tbl.push_back(mkv(2'b01, mkf(PAY, 32'hA300_0000), '0, 2'b01, 2'b01, 1'b0, "t3_cancel"));
    tbl.push_back(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b0, "t3_to_full"));
    tbl.push_back(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b1, "t3_overflow"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(2'b01, mkf(PAY, 32'hA300_0010 + i), '0, 2'b00,
                        (i < 4) ? 2'b01 : 2'b00, 1'b1, $sformatf("t3_drain%0d", i)));

    // Reset state
    rst = 1'b1;
    drive(2'b00, '0, '0, 2'b00);
    chk0 = 1'b1; chk1 = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    foreach (tbl[i]) cycle(tbl[i]);

    // Packet lock on the locking instance only.
    chk0 = 1'b0;
    rst = 1'b1;
    drive(2'b00, '0, '0, 2'b00);
    release_reset();
    cycle(mkv(2'b11, mkf(HDR, 32'hC000_0000), mkf(SGL, 32'hD000_0000), 2'b00, 2'b01, 1'b0, "t4_header"));
    cycle(mkv(2'b11, mkf(PAY, 32'hC000_0001), mkf(SGL, 32'hD000_0000), 2'b00, 2'b01, 1'b0, "t4_payload"));
    cycle(mkv(2'b10, '0, mkf(SGL, 32'hD000_0000), 2'b00, 2'b00, 1'b0, "t4_stall0"));
    cycle(mkv(2'b10, '0, mkf(SGL, 32'hD000_0000), 2'b00, 2'b00, 1'b0, "t4_stall1"));
    cycle(mkv(2'b11, mkf(LST, 32'hC000_0002), mkf(SGL, 32'hD000_0000), 2'b00, 2'b01, 1'b0, "t4_last"));
    cycle(mkv(2'b11, mkf(SGL, 32'hC000_0003), mkf(SGL, 32'hD000_0000), 2'b00, 2'b10, 1'b0, "t4_vc1_after"));
    cycle(mkv(2'b11, mkf(SGL, 32'hC000_0003), mkf(SGL, 32'hD000_0001), 2'b00, 2'b01, 1'b0, "t4_single_nolock"));
    cycle(mkv(2'b11, mkf(SGL, 32'hC000_0004), mkf(SGL, 32'hD000_0001), 2'b00, 2'b10, 1'b0, "t4_vc0_dry"));
    cycle(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b0, "t5_ret0"));
    cycle(mkv(2'b00, '0, '0, 2'b01, 2'b00, 1'b0, "t5_ret1"));
    cycle(mkv(2'b11, mkf(HDR, 32'hE000_0000), mkf(PAY, 32'hF000_0000), 2'b00, 2'b01, 1'b0, "t5_lock"));

    // Asynchronous reset mid-packet, away from any clock edge.
    drive(2'b11, mkf(PAY, 32'hE000_0001), mkf(PAY, 32'hF000_0001), 2'b00);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    chk0 = 1'b1;
    release_reset();
    for (int i = 0; i < 9; i++)
      cycle(mkv(2'b11, mkf(PAY, 32'h5000_0000 + i), mkf(PAY, 32'h6000_0000 + i), 2'b00,
                (i == 8) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10), 1'b0, $sformatf("t5_after%0d", i)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
